// File: rtl/restoring_div_pkg.sv
// rtl/restoring_div_pkg.sv - shared types and constants for the restoring divider tile
package restoring_div_pkg;

   localparam int N_DIVIDEND = 8;
   localparam int N_DIVISOR  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] UIO_OE_IDLE   = 8'b0000_1110;
   localparam logic [7:0] UIO_OE_DONE   = 8'b1111_1110;
   localparam logic [7:0] DIV0_QUOTIENT = 8'hFF;
   localparam logic [7:0] OVF_QUOTIENT  = 8'h7F;
   localparam logic [2:0] LAST_ITER     = 3'd7;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step
   import restoring_div_pkg::*;
(
   input  logic [N_DIVISOR-1:0] rem_in,
   input  logic                 dvd_msb,
   input  logic [N_DIVISOR-1:0] divisor,
   output logic [N_DIVISOR-1:0] rem_out,
   output logic                 q_bit
);

   // rem_in < divisor always, so the shifted partial remainder fits in 5 bits
   // and the restored difference fits back into 4 bits.
   logic [N_DIVISOR:0] r5;
   logic [N_DIVISOR:0] diff;

   // trial subtract; keep the difference only when it does not go negative
   always_comb begin
      r5      = {rem_in, dvd_msb};
      diff    = r5 - {1'b0, divisor};
      q_bit   = (r5 >= {1'b0, divisor});
      rem_out = q_bit ? diff[N_DIVISOR-1:0] : r5[N_DIVISOR-1:0];
   end

endmodule

// File: rtl/tt_um_restoring_div_hhrb98.sv
// rtl/tt_um_restoring_div_hhrb98.sv - 8/4 radix-2 restoring divider tile; DIV_SIGNED_EN selects signed operands
module tt_um_restoring_div_hhrb98
   import restoring_div_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   state_t     state;
   state_t     state_next;
   logic [7:0] dvd;
   logic [7:0] quo;
   logic [3:0] rem;
   logic [3:0] dsr;
   logic [2:0] iter;
   logic       err;

   logic       start;
   logic [3:0] divisor_in;
   logic       capture;
   logic       step;
   logic       busy;
   logic       done;
   logic [3:0] step_rem;
   logic       step_q;

   logic [7:0] mag_dvd;
   logic [3:0] mag_dsr;
   logic       div_zero;
   logic       ovf;

   assign start      = uio_in[0];
   assign divisor_in = uio_in[7:4];
   assign div_zero   = (divisor_in == 4'd0);

   // uio_in[3:1] carry nothing for this tile
   logic unused_uio;
   assign unused_uio = &{1'b0, uio_in[3:1]};

`ifdef DIV_SIGNED_EN
   logic fixup;
   logic fix_pending;
   logic neg_q;
   logic neg_r;

   // operand magnitudes feed the same unsigned core; -128/-1 cannot be represented
   always_comb begin
      mag_dvd = ui_in[7] ? (~ui_in + 8'd1) : ui_in;
      mag_dsr = divisor_in[3] ? (~divisor_in + 4'd1) : divisor_in;
      ovf     = (ui_in == 8'h80) && (divisor_in == 4'hF);
   end
`else
   assign mag_dvd = ui_in;
   assign mag_dsr = divisor_in;
   assign ovf     = 1'b0;
`endif

   div_step u_step (
      .rem_in  (rem),
      .dvd_msb (dvd[7]),
      .divisor (dsr),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // next state, datapath strobes and pin muxing; ena low freezes everything
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      step       = 1'b0;
`ifdef DIV_SIGNED_EN
      fixup      = 1'b0;
`endif
      if (ena) begin
         case (state)
            IDLE: begin
               if (start) begin
                  capture    = 1'b1;
                  state_next = (div_zero || ovf) ? DONE : BUSY;
               end
            end
            BUSY: begin
`ifdef DIV_SIGNED_EN
               if (fix_pending) begin
                  fixup      = 1'b1;
                  state_next = DONE;
               end else begin
                  step = 1'b1;
               end
`else
               step = 1'b1;
               if (iter == LAST_ITER) state_next = DONE;
`endif
            end
            DONE: begin
               if (!start) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end

      busy    = (state == BUSY);
      done    = (state == DONE);
      uo_out  = done ? quo : 8'd0;
      uio_out = {(done ? rem : 4'd0), err, done, busy, 1'b0};
      uio_oe  = done ? UIO_OE_DONE : UIO_OE_IDLE;
   end

   // operand capture, one quotient bit per BUSY cycle, optional sign fix-up
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dvd  <= 8'd0;
         quo  <= 8'd0;
         rem  <= 4'd0;
         dsr  <= 4'd0;
         iter <= 3'd0;
         err  <= 1'b0;
`ifdef DIV_SIGNED_EN
         fix_pending <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`endif
      end else if (capture) begin
         dvd  <= mag_dvd;
         dsr  <= mag_dsr;
         iter <= 3'd0;
`ifdef DIV_SIGNED_EN
         fix_pending <= 1'b0;
         neg_q       <= ui_in[7] ^ divisor_in[3];
         neg_r       <= ui_in[7];
`endif
         if (div_zero) begin
            quo <= DIV0_QUOTIENT;
            rem <= ui_in[3:0];
            err <= 1'b1;
         end else if (ovf) begin
            quo <= OVF_QUOTIENT;
            rem <= 4'd0;
            err <= 1'b1;
         end else begin
            quo <= 8'd0;
            rem <= 4'd0;
            err <= 1'b0;
         end
      end else if (step) begin
         rem  <= step_rem;
         dvd  <= {dvd[6:0], 1'b0};
         quo  <= {quo[6:0], step_q};
         iter <= iter + 3'd1;
`ifdef DIV_SIGNED_EN
         if (iter == LAST_ITER) fix_pending <= 1'b1;
      end else if (fixup) begin
         fix_pending <= 1'b0;
         if (neg_q) quo <= ~quo + 8'd1;
         if (neg_r) rem <= ~rem + 4'd1;
`endif
      end
   end

endmodule

// File: tb/tb_tt_um_restoring_div_hhrb98.sv
// tb/tb_tt_um_restoring_div_hhrb98.sv - directed-vector bench for the restoring divider tile
module tb_tt_um_restoring_div_hhrb98;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int vec_count = 0;
   int err_count = 0;
   int cycles;
   logic first_busy;

`ifdef DIV_SIGNED_EN
   localparam int LAT = 9;
`else
   localparam int LAT = 8;
`endif

   tt_um_restoring_div_hhrb98 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_count++;
      if (obs !== exp) begin
         err_count++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // drive operands with start, wait for done; cycles counts edges after the capture edge
   task automatic run_div(input logic [7:0] a, input logic [3:0] b, input bit hold,
                          output int cyc, output logic busy0);
      ui_in  = a;
      uio_in = {b, 3'b000, 1'b1};
      @(negedge clk);
      busy0 = uio_out[1];
      if (!hold) uio_in[0] = 1'b0;
      cyc = 0;
      while (uio_out[2] !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_uo"},  uo_out,  8'h00);
      check({tag, "_oe"},  uio_oe,  8'h0E);
      check({tag, "_don"}, uio_out[2:0], 3'b000);
   endtask

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'd0;
      uio_in = 8'd0;
      tick(2);
      check("rst_uio", uio_out, 8'h00);
      check_idle("rst");
      rst_n = 1'b1;
      tick(1);

      // enable low blocks capture
      ena = 1'b0;
      ui_in = 8'd100;
      uio_in = {4'd7, 3'b000, 1'b1};
      tick(2);
      check("ena_nocap_busy", uio_out[1], 1'b0);
      uio_in = 8'd0;
      ena = 1'b1;
      tick(1);

`ifndef DIV_SIGNED_EN
      // 100 / 7 = 14 r 2
      run_div(8'd100, 4'd7, 1'b0, cycles, first_busy);
      check("d100_busy0", first_busy, 1'b1);
      check("d100_lat", cycles, LAT);
      check("d100_q", uo_out, 8'd14);
      check("d100_r", uio_out[7:4], 4'd2);
      check("d100_err", uio_out[3], 1'b0);
      check("d100_busy", uio_out[1], 1'b0);
      check("d100_oe", uio_oe, 8'hFE);
      tick(1);
      check_idle("d100_ack");

      // 255 / 1 with start held
      run_div(8'd255, 4'd1, 1'b1, cycles, first_busy);
      check("d255_lat", cycles, LAT);
      tick(3);
      check("d255_q", uo_out, 8'd255);
      check("d255_r", uio_out[7:4], 4'd0);
      check("d255_hold", uio_out[2], 1'b1);
      uio_in[0] = 1'b0;
      tick(1);
      check_idle("d255_ack");

      // 3 / 15 = 0 r 3
      run_div(8'd3, 4'd15, 1'b1, cycles, first_busy);
      check("d3_q", uo_out, 8'd0);
      check("d3_r", uio_out[7:4], 4'd3);
      uio_in[0] = 1'b0;
      tick(1);
      check_idle("d3_ack");
`endif

      // divide by zero: done right after capture
      run_div(8'd200, 4'd0, 1'b1, cycles, first_busy);
      check("dz_lat", cycles, 0);
      check("dz_q", uo_out, 8'hFF);
      check("dz_r", uio_out[7:4], 4'd8);
      check("dz_err", uio_out[3], 1'b1);
      uio_in[0] = 1'b0;
      tick(1);

      // 9 / 3 = 3 r 0, error cleared
      run_div(8'd9, 4'd3, 1'b0, cycles, first_busy);
      check("d9_lat", cycles, LAT);
      check("d9_q", uo_out, 8'd3);
      check("d9_r", uio_out[7:4], 4'd0);
      check("d9_err", uio_out[3], 1'b0);
      tick(1);

      // reset during the 4th iteration
      ui_in  = 8'd100;
      uio_in = {4'd7, 3'b000, 1'b1};
      tick(1);
      uio_in[0] = 1'b0;
      tick(3);
      check("rmid_busy", uio_out[1], 1'b1);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check("rmid_uio", uio_out, 8'h00);
      check_idle("rmid");
      tick(1);
      run_div(8'd100, 4'd7, 1'b0, cycles, first_busy);
      check("rfresh_lat", cycles, LAT);
`ifdef DIV_SIGNED_EN
      check("rfresh_q", uo_out, 8'd14);
`else
      check("rfresh_q", uo_out, 8'd14);
`endif
      check("rfresh_r", uio_out[7:4], 4'd2);
      tick(1);

      // enable low 5 cycles mid-BUSY
      ui_in  = 8'd100;
      uio_in = {4'd7, 3'b000, 1'b1};
      tick(1);
      uio_in[0] = 1'b0;
      tick(3);
      ena = 1'b0;
      tick(5);
      check("efrz_busy", uio_out[1], 1'b1);
      check("efrz_done", uio_out[2], 1'b0);
      ena = 1'b1;
      cycles = 8;
      while (uio_out[2] !== 1'b1 && cycles < 60) begin
         @(negedge clk);
         cycles++;
      end
      check("efrz_lat", cycles, LAT + 5);
      check("efrz_q", uo_out, 8'd14);
      check("efrz_r", uio_out[7:4], 4'd2);
      tick(1);

`ifdef DIV_SIGNED_EN
      // -100 / 7 = -14 r -2
      run_div(8'h9C, 4'h7, 1'b0, cycles, first_busy);
      check("s100_lat", cycles, 9);
      check("s100_q", uo_out, 8'hF2);
      check("s100_r", uio_out[7:4], 4'hE);
      check("s100_err", uio_out[3], 1'b0);
      tick(1);
      // -128 / -1 overflows
      run_div(8'h80, 4'hF, 1'b0, cycles, first_busy);
      check("sovf_q", uo_out, 8'h7F);
      check("sovf_r", uio_out[7:4], 4'h0);
      check("sovf_err", uio_out[3], 1'b1);
      tick(1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule
